// File: rtl/s2p_pkg.sv
// s2p_pkg: shared widths, comma byte, FSM encoding and byte classification for the 4-lane receiver
package s2p_pkg;
  localparam int LANES = 4;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;
  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] SYNC = 1'b1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] MISALIGN = 2'd2;
  function automatic logic [1:0] byte_class(input logic [LANES-1:0] hits);
    return &hits ? IDLE : |hits ? MISALIGN : DATA;
  endfunction
endpackage

// File: rtl/s2p_lane.sv
// s2p_lane: one lane's LSB-first shift register with comma match on the value about to be stored
module s2p_lane
  import s2p_pkg::*;
(
  input  logic              CLK,
  input  logic              reset,
  input  logic              ENB,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] sr_nxt,
  output logic              comma_hit
);
  logic [BYTE_W-1:0] sr;
  assign sr_nxt = {bit_in, sr[BYTE_W-1:1]};
  assign comma_hit = sr_nxt == COMMA;
  always_ff @(posedge CLK or posedge reset)
    if (reset) sr <= '0;
    else if (ENB) sr <= sr_nxt;
endmodule

// File: rtl/s2p_rx_4lane.sv
// s2p_rx_4lane: 4-lane serial-to-parallel receiver with comma alignment and lock-loss detection
// Optional saturating misaligned-byte counter on err_count when S2P_ERR_CNT_EN is defined.
module s2p_rx_4lane
  import s2p_pkg::*;
#(
  parameter logic [3:0] LOSS_THRESH = 4'd4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    ENB,
  input  logic [LANES-1:0]        data_in,
  output logic [LANES*BYTE_W-1:0] data_out,
  output logic                    valid,
  output logic                    sync
`ifdef S2P_ERR_CNT_EN
  ,
  output logic [7:0]              err_count
`endif
);
  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [3:0] bad_cnt;
  logic [LANES-1:0] hit;
  logic [LANES*BYTE_W-1:0] nxt;
  logic [1:0] cls;
  logic done, lose;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    s2p_lane u_lane (
      .CLK(CLK),
      .reset(reset),
      .ENB(ENB),
      .bit_in(data_in[l]),
      .sr_nxt(nxt[l*BYTE_W+:BYTE_W]),
      .comma_hit(hit[l])
    );
  end
  assign cls = byte_class(hit);
  assign done = state == SYNC && bit_cnt == 3'd7;
  assign lose = done && cls == MISALIGN && bad_cnt + 4'd1 == LOSS_THRESH;
  assign sync = state == SYNC;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= SEARCH;
      bit_cnt <= '0;
      bad_cnt <= '0;
      data_out <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (ENB && state == SEARCH && &hit) begin
        state <= SYNC;
        bit_cnt <= '0;
        bad_cnt <= '0;
      end else if (ENB && state == SYNC) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (done) begin
          if (cls == DATA) begin
            data_out <= nxt;
            valid <= 1'b1;
          end
          bad_cnt <= (cls != MISALIGN || lose) ? 4'd0 : bad_cnt + 4'd1;
          if (lose) state <= SEARCH;
        end
      end
    end
`ifdef S2P_ERR_CNT_EN
  always_ff @(posedge CLK or posedge reset)
    if (reset) err_count <= '0;
    else if (ENB && done && cls == MISALIGN && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_s2p_rx_4lane.sv
// tb_s2p_rx_4lane: directed stimulus with a byte-level reference model compared every cycle
module tb_s2p_rx_4lane;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic ENB = 1'b0;
  logic [3:0] data_in = '0;
  logic [31:0] data_out;
  logic valid, sync;
  int vectors = 0;
  int miscompares = 0;
`ifdef S2P_ERR_CNT_EN
  logic [7:0] err_count;
`endif
  s2p_rx_4lane dut (
    .CLK(CLK),
    .reset(reset),
    .ENB(ENB),
    .data_in(data_in),
    .data_out(data_out),
    .valid(valid),
    .sync(sync)
`ifdef S2P_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );
  always #5 CLK = ~CLK;
  int m_sr[4];
  bit m_lock, m_valid;
  int m_bits, m_bad, m_err;
  logic [31:0] m_dout;
  always @(posedge CLK or posedge reset)
    if (reset) begin
      for (int k = 0; k < 4; k++) m_sr[k] = 0;
      m_lock = 0; m_valid = 0; m_bits = 0; m_bad = 0; m_err = 0; m_dout = 0;
    end else begin
      int nx[4];
      int hits;
      m_valid = 0;
      if (ENB) begin
        hits = 0;
        for (int k = 0; k < 4; k++) begin
          nx[k] = (m_sr[k] / 2) + (data_in[k] ? 128 : 0);
          if (nx[k] == 'hBC) hits++;
        end
        if (!m_lock) begin
          if (hits == 4) begin m_lock = 1; m_bits = 0; m_bad = 0; end
        end else begin
          m_bits++;
          if (m_bits == 8) begin
            m_bits = 0;
            if (hits == 4) m_bad = 0;
            else if (hits == 0) begin
              m_dout = 32'(nx[0] + nx[1] * 256 + nx[2] * 65536 + nx[3] * 16777216);
              m_valid = 1; m_bad = 0;
            end else begin
              m_bad++;
              m_err = m_err < 255 ? m_err + 1 : 255;
              if (m_bad == 4) begin m_lock = 0; m_bad = 0; end
            end
          end
        end
        for (int k = 0; k < 4; k++) m_sr[k] = nx[k];
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge CLK) begin
    chk("data_out", data_out, m_dout);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    chk("sync", {31'b0, sync}, {31'b0, m_lock});
`ifdef S2P_ERR_CNT_EN
    chk("err_count", {24'b0, err_count}, 32'(m_err));
`endif
  end
  task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ENB = 1'b1;
      data_in = {w[24+i], w[16+i], w[8+i], w[i]};
      @(posedge CLK); #1;
    end
  endtask
  task automatic send(input logic [31:0] w);
    send_bits(w, 0, 7);
  endtask
  task automatic stall(input int n);
    ENB = 1'b0;
    data_in = 4'hF;
    repeat (n) begin @(posedge CLK); #1; end
  endtask
  task automatic do_reset();
    reset = 1'b1; #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_sync", {31'b0, sync}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    send(32'hBCBCBCBC);
    chk("lock_sync", {31'b0, sync}, 32'h1);
    send(32'h44332211);
    chk("first_word", data_out, 32'h44332211);
    chk("first_valid", {31'b0, valid}, 32'h1);
    stall(1);
    chk("valid_one_cycle", {31'b0, valid}, 32'h0);
    for (int r = 0; r < 2; r++) begin
      send(32'hA5A5A5A5);
      chk("stream_word", data_out, 32'hA5A5A5A5);
      chk("stream_valid", {31'b0, valid}, 32'h1);
      send(32'hBCBCBCBC);
      chk("idle_valid", {31'b0, valid}, 32'h0);
      chk("idle_sync", {31'b0, sync}, 32'h1);
    end
    send_bits(32'h01020304, 0, 3);
    stall(5);
    chk("stall_no_valid", {31'b0, valid}, 32'h0);
    send_bits(32'h01020304, 4, 7);
    chk("stall_word", data_out, 32'h01020304);
    chk("stall_valid", {31'b0, valid}, 32'h1);
    send_bits(32'hA5A5A5A5, 0, 3);
    do_reset();
    send(32'hA5A5A5A5);
    send(32'hA5A5A5A5);
    chk("post_rst_nolock", {31'b0, sync}, 32'h0);
    chk("post_rst_data", data_out, 32'h0);
    send(32'hBCBCBCBC);
    for (int r = 0; r < 3; r++) send(32'h00BC0000);
    chk("loss_hold_sync", {31'b0, sync}, 32'h1);
    send(32'h00BC0000);
    chk("loss_sync", {31'b0, sync}, 32'h0);
`ifdef S2P_ERR_CNT_EN
    chk("loss_err", {24'b0, err_count}, 32'd4);
    send(32'hBCBCBCBC);
    for (int r = 0; r < 300; r++) begin
      send(32'hBC000000);
      send(32'hBCBCBCBC);
    end
    chk("sat_err", {24'b0, err_count}, 32'hFF);
    send(32'hBC000000);
    chk("sat_hold", {24'b0, err_count}, 32'hFF);
`endif
    send(32'hBCBCBCBC);
    send(32'h5A5A5A5A);
    chk("relock_word", data_out, 32'h5A5A5A5A);
    stall(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
